// File: rtl/fetch_resp_buf_if.sv
// fetch_resp_buf_if: handshake bundle between the fetch front end, the
// memory response path and decode for the in-order fetch response buffer.
//   req_*  : fetch allocation (valid/ready, PC)
//   rsp_*  : memory response beat (never back-pressured)
//   out_*  : retire to decode (valid/ready, PC + data)
// Optional macro FETCH_RESP_BUF_ERR_EN adds rsp_err / out_err.
// modport slave  : the buffer side.
// modport master : the side driving requests/responses and accepting output.
interface fetch_resp_buf_if #(
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [PC_WIDTH-1:0]   req_pc;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [PC_WIDTH-1:0]   out_pc;
  logic [DATA_WIDTH-1:0] out_data;
`ifdef FETCH_RESP_BUF_ERR_EN
  logic                  rsp_err;
  logic                  out_err;

  modport slave (
    input  req_valid, req_pc, rsp_valid, rsp_data, rsp_err, out_ready,
    output req_ready, out_valid, out_pc, out_data, out_err
  );
  modport master (
    output req_valid, req_pc, rsp_valid, rsp_data, rsp_err, out_ready,
    input  req_ready, out_valid, out_pc, out_data, out_err
  );
`else
  modport slave (
    input  req_valid, req_pc, rsp_valid, rsp_data, out_ready,
    output req_ready, out_valid, out_pc, out_data
  );
  modport master (
    output req_valid, req_pc, rsp_valid, rsp_data, out_ready,
    input  req_ready, out_valid, out_pc, out_data
  );
`endif
endinterface

// File: rtl/fetch_resp_buf.sv
// fetch_resp_buf: in-order completion buffer for instruction fetch.
// Each accepted request allocates an entry holding its PC; in-order memory
// responses fill entries in allocation order; filled entries retire to decode
// via valid/ready. A flush marks every allocated entry stale; stale entries
// are dropped at the head (one per cycle) once their response has landed.
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   flush          : mark all currently allocated entries stale
//   bus            : fetch_resp_buf_if.slave (req_*, rsp_*, out_*)
//   idle           : no allocated entries
//   rsp_overflow   : sticky, a response arrived with no unfilled entry
// Optional macro FETCH_RESP_BUF_ERR_EN: per-entry error bit, rsp_err -> out_err.
module fetch_resp_buf #(
  parameter int ADDR_WIDTH = 4,
  parameter int PC_WIDTH   = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               flush,
  fetch_resp_buf_if.slave    bus,
  output logic               idle,
  output logic               rsp_overflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0] ptr_t;
  typedef logic [ADDR_WIDTH:0]   cnt_t;

  localparam cnt_t FULL = cnt_t'(DEPTH);

  ptr_t a_ptr_q, a_ptr_d;
  ptr_t f_ptr_q, f_ptr_d;
  ptr_t r_ptr_q, r_ptr_d;
  cnt_t cnt_q, cnt_d;
  cnt_t unf_q, unf_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [DEPTH-1:0] stale_q, stale_d;
  logic             ovf_q, ovf_d;

  logic [DEPTH-1:0][PC_WIDTH-1:0]   pc_q, pc_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
`ifdef FETCH_RESP_BUF_ERR_EN
  logic [DEPTH-1:0] err_q, err_d;
`endif

  logic alloc, fill, head_live, drop, retire, out_valid;

  assign bus.req_ready = (cnt_q != FULL);
  assign alloc         = bus.req_valid & bus.req_ready;
  assign fill          = bus.rsp_valid & (unf_q != '0);

  // Head is retireable only once its response has landed; stale heads are
  // dropped without being offered, live heads wait for decode.
  assign head_live = filled_q[r_ptr_q] & (cnt_q != '0);
  assign out_valid = head_live & ~stale_q[r_ptr_q] & ~flush;
  assign drop      = head_live & stale_q[r_ptr_q];
  assign retire    = (out_valid & bus.out_ready) | drop;

  assign bus.out_valid = out_valid;
  assign bus.out_pc    = pc_q[r_ptr_q];
  assign bus.out_data  = data_q[r_ptr_q];
`ifdef FETCH_RESP_BUF_ERR_EN
  assign bus.out_err   = err_q[r_ptr_q];
`endif

  assign idle         = (cnt_q == '0);
  assign rsp_overflow = ovf_q;

  always_comb begin
    a_ptr_d  = a_ptr_q;
    f_ptr_d  = f_ptr_q;
    r_ptr_d  = r_ptr_q;
    cnt_d    = cnt_q;
    unf_d    = unf_q;
    filled_d = filled_q;
    stale_d  = stale_q;
    ovf_d    = ovf_q | (bus.rsp_valid & (unf_q == '0));
    pc_d     = pc_q;
    data_d   = data_q;
`ifdef FETCH_RESP_BUF_ERR_EN
    err_d    = err_q;
`endif

    // Allocated entries are the cnt_q slots starting at the head.
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        if ({1'b0, ptr_t'(ptr_t'(i) - r_ptr_q)} < cnt_q) stale_d[i] = 1'b1;
      end
    end

    if (retire) begin
      filled_d[r_ptr_q] = 1'b0;
      r_ptr_d           = r_ptr_q + ptr_t'(1);
    end

    if (fill) begin
      filled_d[f_ptr_q] = 1'b1;
      data_d[f_ptr_q]   = bus.rsp_data;
`ifdef FETCH_RESP_BUF_ERR_EN
      err_d[f_ptr_q]    = bus.rsp_err;
`endif
      f_ptr_d           = f_ptr_q + ptr_t'(1);
    end

    // a_ptr_q is never an allocated slot when alloc fires, so this cannot
    // collide with the flush marking above: same-cycle allocations stay live.
    if (alloc) begin
      filled_d[a_ptr_q] = 1'b0;
      stale_d[a_ptr_q]  = 1'b0;
      pc_d[a_ptr_q]     = bus.req_pc;
      a_ptr_d           = a_ptr_q + ptr_t'(1);
    end

    if (alloc && !retire)      cnt_d = cnt_q + cnt_t'(1);
    else if (!alloc && retire) cnt_d = cnt_q - cnt_t'(1);

    if (alloc && !fill)        unf_d = unf_q + cnt_t'(1);
    else if (!alloc && fill)   unf_d = unf_q - cnt_t'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_ptr_q  <= '0;
      f_ptr_q  <= '0;
      r_ptr_q  <= '0;
      cnt_q    <= '0;
      unf_q    <= '0;
      filled_q <= '0;
      stale_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      a_ptr_q  <= a_ptr_d;
      f_ptr_q  <= f_ptr_d;
      r_ptr_q  <= r_ptr_d;
      cnt_q    <= cnt_d;
      unf_q    <= unf_d;
      filled_q <= filled_d;
      stale_q  <= stale_d;
      ovf_q    <= ovf_d;
    end
  end

  // Payload storage carries no reset; it is only observed behind filled bits.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    data_q <= data_d;
`ifdef FETCH_RESP_BUF_ERR_EN
    err_q  <= err_d;
`endif
  end

endmodule

// File: tb/tb_fetch_resp_buf.sv
// tb_fetch_resp_buf: table-driven vectors plus scoreboard for fetch_resp_buf.
// Inputs are driven on the falling edge and outputs sampled 1ns later.
module tb_fetch_resp_buf;
  localparam int AW = 4, PCW = 32, DW = 32;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  logic idle, rsp_overflow;

  fetch_resp_buf_if #(.PC_WIDTH(PCW), .DATA_WIDTH(DW)) bif();

  fetch_resp_buf #(.ADDR_WIDTH(AW), .PC_WIDTH(PCW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bus(bif),
    .idle(idle), .rsp_overflow(rsp_overflow)
  );

  always #5 clk = ~clk;

  typedef struct { logic [PCW-1:0] pc; logic stale; } pend_t;
  typedef struct { logic [PCW-1:0] pc; logic [DW-1:0] data; logic err; } exp_t;
  typedef struct {
    logic rq; logic [31:0] pc; logic rs; logic [31:0] d; logic er;
    logic ordy; logic fl;
    logic chk; logic e_rr; logic e_ov; logic [31:0] e_pc; logic [31:0] e_data; logic e_idle;
  } vec_t;

  pend_t pend_q[$];
  exp_t  exp_q[$];
  logic  ovf_m;
  int    n_chk = 0, n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mv(input logic rq, input logic [31:0] pc, input logic rs,
                              input logic [31:0] d, input logic er, input logic ordy,
                              input logic fl);
    vec_t v;
    v = '{rq, pc, rs, d, er, ordy, fl, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0};
    return v;
  endfunction

  // One clock cycle: drive, sample, score, update model, wait for next negedge.
  task automatic run(input vec_t v);
    exp_t e;
    pend_t p;
    logic acc;
    bif.req_valid = v.rq;
    bif.req_pc    = v.pc;
    bif.rsp_valid = v.rs;
    bif.rsp_data  = v.d;
`ifdef FETCH_RESP_BUF_ERR_EN
    bif.rsp_err   = v.er;
`endif
    bif.out_ready = v.ordy;
    flush         = v.fl;
    #1;
    check("rsp_overflow", rsp_overflow, ovf_m);
    if (v.fl) check("flush_blocks_out_valid", bif.out_valid, 1'b0);
    if (v.chk) begin
      check("vec_req_ready", bif.req_ready, v.e_rr);
      check("vec_out_valid", bif.out_valid, v.e_ov);
      check("vec_idle", idle, v.e_idle);
      if (v.e_ov) begin
        check("vec_out_pc", bif.out_pc, v.e_pc);
        check("vec_out_data", bif.out_data, v.e_data);
      end
    end
    if (bif.out_valid && bif.out_ready) begin
      if (exp_q.size() == 0) begin
        n_chk++; n_fail++;
        $display("FAIL unexpected_output: got pc %0h, expected no output", bif.out_pc);
      end else begin
        e = exp_q.pop_front();
        check("sb_out_pc", bif.out_pc, e.pc);
        check("sb_out_data", bif.out_data, e.data);
`ifdef FETCH_RESP_BUF_ERR_EN
        check("sb_out_err", bif.out_err, e.err);
`endif
      end
    end
    acc = v.rq && bif.req_ready;
    if (v.rs) begin
      if (pend_q.size() == 0) ovf_m = 1'b1;
      else begin
        p = pend_q.pop_front();
        if (!p.stale) exp_q.push_back('{p.pc, v.d, v.er});
      end
    end
    if (v.fl) begin
      foreach (pend_q[i]) pend_q[i].stale = 1'b1;
      exp_q.delete();
    end
    if (acc) pend_q.push_back('{v.pc, 1'b0});
    @(negedge clk);
  endtask

  task automatic do_reset();
    run(mv(0, 0, 0, 0, 0, 0, 0));
    reset_n = 1'b0;
    pend_q.delete();
    exp_q.delete();
    ovf_m = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
  endtask

  // Retire everything outstanding; responses supplied only while some are owed.
  task automatic drain(input string name);
    int n;
    n = 0;
    while (!(idle && pend_q.size() == 0) && n < 200) begin
      run(mv(0, 0, pend_q.size() > 0, 32'hD000 + n, 0, 1, 0));
      n++;
    end
    check({name, "_drain_idle"}, idle, 1'b1);
    check({name, "_drain_sb_empty"}, exp_q.size(), 0);
  endtask

  vec_t tbl[6];
  logic [31:0] held_pc;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ovf_m = 1'b0;
    bif.req_valid = 0; bif.req_pc = 0; bif.rsp_valid = 0; bif.rsp_data = 0; bif.out_ready = 0;
`ifdef FETCH_RESP_BUF_ERR_EN
    bif.rsp_err = 0;
`endif
    //           rq    pc       rs    d       er    ordy  fl    chk   rr    ov    pc        data    idle
    tbl[0] = '{1'b1, 32'h100, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0, 1'b1};
    tbl[1] = '{1'b1, 32'h104, 1'b1, 32'hA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0, 1'b0};
    tbl[2] = '{1'b1, 32'h108, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h100, 32'hA, 1'b0};
    tbl[3] = '{1'b0, 32'h0,   1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h104, 32'hB, 1'b0};
    tbl[4] = '{1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 32'h108, 32'hC, 1'b0};
    tbl[5] = '{1'b0, 32'h0,   1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0,   32'h0, 1'b1};

    @(negedge clk);
    do_reset();
    check("reset_req_ready", bif.req_ready, 1'b1);
    check("reset_out_valid", bif.out_valid, 1'b0);
    check("reset_idle", idle, 1'b1);
    check("reset_overflow", rsp_overflow, 1'b0);

    // Basic in-order flow
    for (int i = 0; i < 6; i++) run(tbl[i]);

    // Fill to capacity, free one slot, then stream across pointer wrap
    do_reset();
    for (int i = 0; i < 16; i++) run(mv(1, 32'h1000 + 4*i, 0, 0, 0, 0, 0));
    check("full_req_ready", bif.req_ready, 1'b0);
    run(mv(1, 32'hDEAD, 0, 0, 0, 0, 0));
    run(mv(0, 0, 1, 32'h55, 0, 0, 0));
    check("full_head_valid", bif.out_valid, 1'b1);
    check("full_still_not_ready", bif.req_ready, 1'b0);
    run(mv(0, 0, 0, 0, 0, 1, 0));
    check("full_ready_after_retire", bif.req_ready, 1'b1);
    for (int i = 0; i < 48; i++)
      run(mv(1, 32'h2000 + 4*i, pend_q.size() > 0, 32'h9000 + i, 0, 1, 0));
    drain("wrap");

    // Flush with 4 outstanding, new request in flush cycle
    do_reset();
    for (int i = 0; i < 4; i++) run(mv(1, 32'h10 + 4*i, 0, 0, 0, 1, 0));
    run(mv(1, 32'h200, 0, 0, 0, 1, 1));
    for (int i = 0; i < 5; i++) run(mv(0, 0, 1, 32'hE0 + i, 0, 1, 0));
    check("flush_live_valid", bif.out_valid, 1'b1);
    check("flush_live_pc", bif.out_pc, 32'h200);
    check("flush_live_data", bif.out_data, 32'hE4);
    run(mv(0, 0, 0, 0, 0, 1, 0));
    check("flush_idle_after", idle, 1'b1);

    // Flush while a live head is presented with out_ready high
    run(mv(1, 32'h300, 0, 0, 0, 0, 0));
    run(mv(0, 0, 1, 32'h33, 0, 0, 0));
    check("preflush_head_valid", bif.out_valid, 1'b1);
    run(mv(0, 0, 0, 0, 0, 1, 1));
    check("postflush_not_idle", idle, 1'b0);
    run(mv(0, 0, 0, 0, 0, 1, 0));
    check("stale_drop_idle", idle, 1'b1);

    // Orphan response: sticky overflow, async clear
    do_reset();
    run(mv(0, 0, 1, 32'h77, 0, 1, 0));
    repeat (3) run(mv(0, 0, 0, 0, 0, 1, 0));
    check("ovf_sticky", rsp_overflow, 1'b1);
    check("ovf_idle", idle, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    check("async_clear_ovf", rsp_overflow, 1'b0);
    check("async_req_ready", bif.req_ready, 1'b1);
    pend_q.delete(); exp_q.delete(); ovf_m = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    // Reset mid-operation: the in-flight response becomes an orphan
    run(mv(1, 32'h40, 0, 0, 0, 0, 0));
    run(mv(1, 32'h44, 0, 0, 0, 0, 0));
    do_reset();
    check("midreset_idle", idle, 1'b1);
    run(mv(0, 0, 1, 32'h88, 0, 1, 0));
    check("midreset_orphan", rsp_overflow, 1'b1);

    // Back-pressure: hold 8 filled entries, then release under full traffic
    do_reset();
    for (int i = 0; i < 9; i++) begin
      run(mv(i < 8, 32'h400 + 4*i, i > 0, 32'hA00 + i, 0, 0, 0));
      if (i == 1) held_pc = bif.out_pc;
      if (i >= 1) begin
        check("hold_valid", bif.out_valid, 1'b1);
        check("hold_pc_stable", bif.out_pc, 32'h400);
      end
    end
    for (int i = 0; i < 8; i++) begin
      check("release_valid", bif.out_valid, 1'b1);
      run(mv(1, 32'h500 + 4*i, pend_q.size() > 0, 32'hB00 + i, 0, 1, 0));
    end
    drain("release");
    check("release_req_ready", bif.req_ready, 1'b1);

`ifdef FETCH_RESP_BUF_ERR_EN
    do_reset();
    run(mv(1, 32'h300, 0, 0, 0, 0, 0));
    run(mv(1, 32'h304, 1, 32'h1, 1, 0, 0));
    run(mv(0, 0, 1, 32'h2, 0, 0, 0));
    check("err_pc", bif.out_pc, 32'h300);
    check("err_bit_set", bif.out_err, 1'b1);
    run(mv(0, 0, 0, 0, 0, 1, 0));
    check("good_pc", bif.out_pc, 32'h304);
    check("err_bit_clear", bif.out_err, 1'b0);
    drain("err");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
